// File: rtl/sid_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : sid_i2s_tx
//  Purpose  : I2S master transmitter for the SID stereo mix. Captures each
//             strobed 48-bit sample {left[23:0], right[23:0]} into a holding
//             register and serialises it as standard I2S (64 BCLKs per frame,
//             32-bit slots, 24 data bits MSB first, one BCLK of delay after
//             the LRCLK edge).
//  Ports    : clk         system clock, all logic on posedge
//             rst         asynchronous active-high reset
//             audio_i     {left, right} signed 24-bit samples
//             audio_stb   1-cycle strobe, audio_i valid
//             i2s_bclk    bit clock, 50% duty, clk/(2*BCLK_DIV)
//             i2s_lrclk   word select, 0 = left slot, 1 = right slot
//             i2s_sd      serial data, changes on BCLK falling edge
//             frame_o     1-cycle pulse when a new frame is loaded
//             underrun_o  1-cycle pulse with frame_o if no new sample arrived
//  Revision : 1.0  initial release
// ============================================================================
module sid_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] audio_i,
    input  logic        audio_stb,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sd,
    output logic        frame_o,
    output logic        underrun_o
);

    localparam int                 c_DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(BCLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_bclk;
    logic               r_lrclk;
    logic               r_sd;
    logic [5:0]         r_bit_cnt;
    logic [47:0]        r_hold;
    logic [47:0]        r_frame;
    logic               r_fresh;
    logic               r_frame_pulse;
    logic               r_underrun;

    logic               w_div_wrap;
    logic               w_fall;
    logic               w_load;
    logic [5:0]         w_bit_nxt;
    logic [4:0]         w_p;
    logic [4:0]         w_idx;
    logic [23:0]        w_word;
    logic               w_sd_nxt;

    // ------------------------------------------------------------------------
    // Next-bit computation. Everything is evaluated for the bit position the
    // counter is about to enter, so the flops present that bit right after
    // the BCLK falling edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_div_wrap = (r_div == c_DIV_MAX);
        w_fall     = w_div_wrap & r_bclk;
        w_bit_nxt  = r_bit_cnt + 6'd1;
        w_load     = w_fall & (w_bit_nxt == 6'd0);
        w_p        = w_bit_nxt[4:0];
        w_idx      = 5'd24 - w_p;
        w_word     = w_bit_nxt[5] ? r_frame[23:0] : r_frame[47:24];
        w_sd_nxt   = 1'b0;
        // Slot position 0 is the I2S one-bit delay; 25..31 are zero padding.
        if ((w_p >= 5'd1) && (w_p <= 5'd24)) begin
            w_sd_nxt = w_word[w_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Bit-clock divider
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_div_wrap) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Serial shifter and frame load. The frame register latches the holding
    // register value from before any same-cycle capture.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt     <= 6'd63;
            r_lrclk       <= 1'b1;
            r_sd          <= 1'b0;
            r_frame       <= '0;
            r_frame_pulse <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_pulse <= 1'b0;
            r_underrun    <= 1'b0;
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= w_bit_nxt[5];
                r_sd      <= w_sd_nxt;
                if (w_load) begin
                    r_frame       <= r_hold;
                    r_frame_pulse <= 1'b1;
                    r_underrun    <= ~r_fresh;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Holding register. A capture in the load cycle wins over the clear, so
    // that sample still counts as fresh for the following frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold  <= '0;
            r_fresh <= 1'b0;
        end else if (audio_stb) begin
            r_hold  <= audio_i;
            r_fresh <= 1'b1;
        end else if (w_load) begin
            r_fresh <= 1'b0;
        end
    end

    assign i2s_bclk   = r_bclk;
    assign i2s_lrclk  = r_lrclk;
    assign i2s_sd     = r_sd;
    assign frame_o    = r_frame_pulse;
    assign underrun_o = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sid_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sid_i2s_tx
//  Purpose  : Self-checking bench for sid_i2s_tx. Three instances with
//             BCLK_DIV = 4, 1 and 7 share clock and reset; an I2S decoder
//             rebuilds each frame from the pins and checks slot format,
//             BCLK duty/period and frame period against a sample model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sid_i2s_tx;

    logic        clk;
    logic        rst;
    logic [2:0]  stb;
    logic [47:0] aud [3];
    logic [2:0]  bclk_w, lr_w, sd_w, fr_w, ur_w;

    int n_vec = 0;
    int n_bad = 0;

    // current per-frame strobe plan: capture edge index (1..128*DIV) and data
    int          s_n;
    int          s_pos [4];
    logic [47:0] s_dat [4];

    typedef struct {
        int          mode;      // 0 none, 1 single, 2 coincident with load, 3 triple
        logic [47:0] smp;
        logic [47:0] exp_data;  // expected content of the following frame
        logic        exp_ur;
    } vec_t;
    vec_t tbl [6];

    sid_i2s_tx #(.BCLK_DIV(4)) u_d4 (
        .clk(clk), .rst(rst), .audio_i(aud[0]), .audio_stb(stb[0]),
        .i2s_bclk(bclk_w[0]), .i2s_lrclk(lr_w[0]), .i2s_sd(sd_w[0]),
        .frame_o(fr_w[0]), .underrun_o(ur_w[0]));
    sid_i2s_tx #(.BCLK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .audio_i(aud[1]), .audio_stb(stb[1]),
        .i2s_bclk(bclk_w[1]), .i2s_lrclk(lr_w[1]), .i2s_sd(sd_w[1]),
        .frame_o(fr_w[1]), .underrun_o(ur_w[1]));
    sid_i2s_tx #(.BCLK_DIV(7)) u_d7 (
        .clk(clk), .rst(rst), .audio_i(aud[2]), .audio_stb(stb[2]),
        .i2s_bclk(bclk_w[2]), .i2s_lrclk(lr_w[2]), .i2s_sd(sd_w[2]),
        .frame_o(fr_w[2]), .underrun_o(ur_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "timeout");
    end

    function automatic int div_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive the strobe plan over one frame starting at a frame_o sample point.
    task automatic stim(input int k);
        int d = div_of(k);
        for (int c = 1; c <= 128 * d; c++) begin
            stb[k] = 1'b0;
            aud[k] = {16'($urandom), $urandom};
            for (int e = 0; e < s_n; e++) begin
                if (s_pos[e] == c) begin
                    stb[k] = 1'b1;
                    aud[k] = s_dat[e];
                end
            end
            @(negedge clk);
        end
        stb[k] = 1'b0;
    endtask

    // Reference I2S decoder: called where frame_o is seen, samples SD/LRCLK
    // on every BCLK rise, returns at the next frame_o.
    task automatic decode(input int k, output logic [47:0] got, output logic ur, output int err);
        int         d, cyc, nb, hi, first_r, last_r, p;
        logic       prev;
        logic [63:0] sdv, lrv;
        d = div_of(k);
        got = '0; err = 0; sdv = '0; lrv = '0;
        ur = ur_w[k];
        if (fr_w[k] !== 1'b1) err++;
        prev = bclk_w[k];
        cyc = 0; nb = 0; hi = 0; first_r = 0; last_r = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bclk_w[k] === 1'b1) hi++;
            if (bclk_w[k] === 1'b1 && prev === 1'b0 && nb < 64) begin
                sdv[nb] = sd_w[k];
                lrv[nb] = lr_w[k];
                if (nb == 0) first_r = cyc;
                last_r = cyc;
                nb++;
            end
            prev = bclk_w[k];
        end while (fr_w[k] !== 1'b1 && cyc < 200 * d);
        if (nb != 64)                     err++;
        if (cyc != 128 * d)               err++;
        if (hi != 64 * d)                 err++;
        if (first_r != d)                 err++;
        if (last_r - first_r != 126 * d)  err++;
        for (int j = 0; j < 64; j++) begin
            p = j % 32;
            if (lrv[j] !== (j >= 32)) err++;
            if (p >= 1 && p <= 24) begin
                if (j < 32) got[48 - p] = sdv[j];
                else        got[24 - p] = sdv[j];
            end else if (sdv[j] !== 1'b0) begin
                err++;
            end
        end
    endtask

    task automatic run_frame(input int k, input logic [47:0] exp_d, input logic exp_u, input string tag);
        logic [47:0] got;
        logic        ur;
        int          err;
        fork
            stim(k);
            decode(k, got, ur, err);
        join
        chk({tag, "_data"}, got, exp_d);
        chk({tag, "_underrun"}, {47'd0, ur}, {47'd0, exp_u});
        chk({tag, "_format"}, 48'(err), 48'd0);
    endtask

    task automatic wait_frame(input int k);
        int cnt = 0;
        while (fr_w[k] !== 1'b1 && cnt < 300 * div_of(k)) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("wait_frame%0d", k), {47'd0, fr_w[k]}, 48'd1);
    endtask

    task automatic build(input int mode, input logic [47:0] smp, input int d);
        s_n = 0;
        case (mode)
            1: begin s_n = 1; s_pos[0] = 5 * d;   s_dat[0] = smp; end
            2: begin s_n = 1; s_pos[0] = 128 * d; s_dat[0] = smp; end
            3: begin
                s_n = 3;
                s_pos[0] = 3;       s_dat[0] = {16'($urandom), $urandom};
                s_pos[1] = 40 * d;  s_dat[1] = {16'($urandom), $urandom};
                s_pos[2] = 100 * d; s_dat[2] = smp;
            end
            default: s_n = 0;
        endcase
    endtask

    initial begin
        logic [47:0] pd, m_hold, nx, cd;
        logic        pu, m_carry, got_norm, coin;
        int          first [3];
        int          d, nn, c;

        tbl[0] = '{1, 48'hA55AC3_800001, 48'hA55AC3_800001, 1'b0};
        tbl[1] = '{2, 48'h123456_654321, 48'hA55AC3_800001, 1'b1};
        tbl[2] = '{0, 48'h0,             48'h123456_654321, 1'b0};
        tbl[3] = '{0, 48'h0,             48'h123456_654321, 1'b1};
        tbl[4] = '{3, 48'h7FFFFF_000000, 48'h7FFFFF_000000, 1'b0};
        tbl[5] = '{1, 48'hFFFFFF_FFFFFF, 48'hFFFFFF_FFFFFF, 1'b0};

        rst = 1'b1;
        stb = '0;
        for (int k = 0; k < 3; k++) aud[k] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_outputs%0d", k),
                {43'd0, bclk_w[k], lr_w[k], sd_w[k], fr_w[k], ur_w[k]}, 48'b01000);

        // first frame_o latency: 2*BCLK_DIV edges after release
        rst = 1'b0;
        first = '{0, 0, 0};
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (fr_w[k] === 1'b1 && first[k] == 0) first[k] = i;
        end
        for (int k = 0; k < 3; k++)
            chk($sformatf("first_frame_latency%0d", k), 48'(first[k]), 48'(2 * div_of(k)));

        // table-driven frame scenarios on the BCLK_DIV=4 instance
        wait_frame(0);
        pd = '0;
        pu = 1'b1;
        for (int j = 0; j < 6; j++) begin
            build(tbl[j].mode, tbl[j].smp, 4);
            run_frame(0, pd, pu, $sformatf("tbl%0d", j));
            pd = tbl[j].exp_data;
            pu = tbl[j].exp_ur;
        end
        s_n = 0;
        run_frame(0, pd, pu, "tbl_end");

        // mid-frame reset during bit 40 while BCLK is high
        repeat (324) @(negedge clk);
        chk("pre_reset_bclk", {47'd0, bclk_w[0]}, 48'd1);
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs",
               {43'd0, bclk_w[0], lr_w[0], sd_w[0], fr_w[0], ur_w[0]}, 48'b01000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = 0;
        while (fr_w[0] !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("post_reset_latency", 48'(c), 48'd8);
        s_n = 0;
        run_frame(0, 48'd0, 1'b1, "post_reset");

        // randomized frames on all instances against the sample model
        for (int k = 0; k < 3; k++) begin
            d = div_of(k);
            m_hold = '0;
            m_carry = 1'b0;
            pd = '0;
            pu = 1'b1;
            wait_frame(k);
            for (int f = 0; f < 6; f++) begin
                s_n = 0;
                nn = int'($urandom_range(0, 3));
                for (int j = 0; j < nn; j++) begin
                    s_pos[s_n] = j * 40 * d + int'($urandom_range(1, 30 * d));
                    s_dat[s_n] = {16'($urandom), $urandom};
                    s_n++;
                end
                if ($urandom_range(0, 3) == 0) begin
                    s_pos[s_n] = 128 * d;
                    s_dat[s_n] = {16'($urandom), $urandom};
                    s_n++;
                end
                run_frame(k, pd, pu, $sformatf("rnd_div%0d_f%0d", d, f));
                // last strobe inside the frame wins; a strobe on the load
                // edge only reaches the frame after next
                got_norm = 1'b0; coin = 1'b0; nx = m_hold; cd = '0;
                for (int e = 0; e < s_n; e++) begin
                    if (s_pos[e] == 128 * d) begin
                        coin = 1'b1;
                        cd = s_dat[e];
                    end else begin
                        got_norm = 1'b1;
                        nx = s_dat[e];
                    end
                end
                pd = nx;
                pu = !got_norm && !m_carry;
                m_hold = coin ? cd : nx;
                m_carry = coin;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
